// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 constants: icodes, ALU ops, condition codes
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_t;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   // cc register is {ZF,SF,OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RESET = 3'b100;

   // jXX/cmovXX condition from the flag register; undefined ifun gives 0
   function automatic logic cond_eval(input logic [2:0] flags, input logic [3:0] fn);
      logic zf, sf, of;
      zf = flags[CC_ZF];
      sf = flags[CC_SF];
      of = flags[CC_OF];
      case (fn)
         C_YES:   cond_eval = 1'b1;
         C_LE:    cond_eval = (sf ^ of) | zf;
         C_L:     cond_eval = sf ^ of;
         C_E:     cond_eval = zf;
         C_NE:    cond_eval = !zf;
         C_GE:    cond_eval = !(sf ^ of);
         C_G:     cond_eval = !(sf ^ of) && !zf;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit Y86 ALU computing Y op X with signed overflow flag
module alu
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [1:0]   control,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   output logic [W-1:0] Z,
   output logic         ovf
);

   // X is the A operand, Y the B operand; subtract forms Y - X
   always_comb begin
      Z   = '0;
      ovf = 1'b0;
      case (control)
         ALU_ADD: begin
            Z   = Y + X;
            ovf = (X[W-1] == Y[W-1]) && (Z[W-1] != Y[W-1]);
         end
         ALU_SUB: begin
            Z   = Y - X;
            ovf = (X[W-1] != Y[W-1]) && (Z[W-1] != Y[W-1]);
         end
         ALU_AND: Z = Y & X;
         default: Z = Y ^ X;
      endcase
   end

endmodule

// File: rtl/y86_execute_stage.sv
// rtl/y86_execute_stage.sv - registered Y86 execute stage with CC register and cond logic
module y86_execute_stage
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] valA,
   input  logic [W-1:0] valB,
   input  logic [W-1:0] valC,
   input  logic         cc_hold,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] valE,
   output logic         cnd,
   output logic         err,
   output logic [2:0]   cc
);

   alu_op_t    alu_ctl;
   logic [W-1:0] alu_x;
   logic [W-1:0] alu_y;
   logic [W-1:0] alu_z;
   logic       alu_ovf;
   logic       accept;
   logic       bad;
   logic       cnd_next;
   logic       cc_we;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   alu #(.W(W)) u_alu (
      .control (alu_ctl),
      .X       (alu_x),
      .Y       (alu_y),
      .Z       (alu_z),
      .ovf     (alu_ovf)
   );

   // route operands to the ALU per instruction; unused icodes produce 0 + 0
   always_comb begin
      alu_ctl = ALU_ADD;
      alu_x   = '0;
      alu_y   = '0;
      case (icode)
         I_OPQ: begin
            alu_ctl = alu_op_t'(ifun[1:0]);
            alu_x   = valA;
            alu_y   = valB;
         end
         I_IRMOVQ:          alu_x = valC;
         I_RRMOVQ:          alu_x = valA;
         I_RMMOVQ, I_MRMOVQ: begin
            alu_x = valC;
            alu_y = valB;
         end
         I_CALL, I_PUSHQ: begin
            alu_ctl = ALU_SUB;
            alu_x   = W'(8);
            alu_y   = valB;
         end
         I_RET, I_POPQ: begin
            alu_x = W'(8);
            alu_y = valB;
         end
         default: ;
      endcase
   end

   // flag encodings this stage cannot execute
   always_comb begin
      bad = 1'b0;
      if (icode > I_POPQ)
         bad = 1'b1;
      else if (icode == I_OPQ && ifun > 4'd3)
         bad = 1'b1;
      else if ((icode == I_RRMOVQ || icode == I_JXX) && ifun > C_G)
         bad = 1'b1;
   end

   // condition uses the flags held before this instruction's own update
   assign cnd_next = !bad && (icode == I_RRMOVQ || icode == I_JXX) && cond_eval(cc, ifun);
   assign cc_we    = accept && !bad && icode == I_OPQ && !cc_hold;

   // output register: load on accept, release when downstream takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         valE      <= '0;
         cnd       <= 1'b0;
         err       <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         valE      <= bad ? '0 : alu_z;
         cnd       <= cnd_next;
         err       <= bad;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // condition-code register written only by legal, unheld OPq
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cc <= CC_RESET;
      else if (cc_we)
         cc <= {alu_z == '0, alu_z[W-1], alu_ovf};
   end

endmodule
